// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Radix-2 Booth codes seen in the two low product bits.
   localparam logic [1:0] BOOTH_ADD = 2'b01;
   localparam logic [1:0] BOOTH_SUB = 2'b10;

   // Operand width after sign/zero extension; one extra bit lets unsigned
   // operands be treated as positive two's-complement values.
   function automatic int unsigned ext_width(input int unsigned width);
      return width + 1;
   endfunction

endpackage

// File: rtl/booth_mult_if.sv
// Start/Busy/Done handshake and operand/result bus of the Booth multiplier.
interface booth_mult_if #(
   parameter int unsigned WIDTH = 32
);
   logic             Start;
   logic             Signed;
   logic [WIDTH-1:0] MultA;
   logic [WIDTH-1:0] MultB;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] Hi;
   logic [WIDTH-1:0] Lo;

   modport master (
      output Start, Signed, MultA, MultB,
      input  Busy, Done, Hi, Lo
   );

   modport slave (
      input  Start, Signed, MultA, MultB,
      output Busy, Done, Hi, Lo
   );
endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract, then arithmetic shift.
module booth_step
   import mult_pkg::*;
#(
   parameter int unsigned E = 33
) (
   input  logic [2*E:0] i_p,
   input  logic [E-1:0] i_a,
   input  logic [E-1:0] i_s,
   output logic [2*E:0] o_p_c
);

   logic [2*E:0] w_sum;

   // Add +A or -A aligned to the top E bits depending on the Booth pair.
   always_comb begin
      w_sum = i_p;
      case (i_p[1:0])
         BOOTH_ADD: w_sum = i_p + {i_a, {(E+1){1'b0}}};
         BOOTH_SUB: w_sum = i_p + {i_s, {(E+1){1'b0}}};
         default:   w_sum = i_p;
      endcase
   end

   // Arithmetic shift right: replicate the sign bit.
   assign o_p_c = {w_sum[2*E], w_sum[2*E:1]};

endmodule

// File: rtl/booth_mult.sv
// Sequential radix-2 Booth multiplier, signed/unsigned, fixed WIDTH+2 latency.
module booth_mult
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic         Clk,
   input  logic         Reset_n,
   booth_mult_if.slave  bus
);

   localparam int unsigned E  = ext_width(WIDTH);
   localparam int unsigned PW = 2*E + 1;
   localparam int unsigned CW = $clog2(WIDTH + 2);
   localparam logic [CW-1:0] CNT_LAST = CW'(E - 1);

   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_cnt,   w_cnt_nxt;
   logic [PW-1:0]   r_p,     w_p_nxt;
   logic [E-1:0]    r_a,     w_a_nxt;
   logic [E-1:0]    r_s,     w_s_nxt;
   logic            r_busy,  w_busy_nxt;
   logic            r_done,  w_done_nxt;
   logic [WIDTH-1:0] r_hi,   w_hi_nxt;
   logic [WIDTH-1:0] r_lo,   w_lo_nxt;

   logic [E-1:0]    w_a_ext;
   logic [E-1:0]    w_b_ext;
   logic [PW-1:0]   w_p_step;

   // Extend operands by one bit: sign bit in signed mode, zero otherwise.
   assign w_a_ext = {bus.Signed & bus.MultA[WIDTH-1], bus.MultA};
   assign w_b_ext = {bus.Signed & bus.MultB[WIDTH-1], bus.MultB};

   booth_step #(.E(E)) u_step (
      .i_p   (r_p),
      .i_a   (r_a),
      .i_s   (r_s),
      .o_p_c (w_p_step)
   );

   // State register.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state, datapath and output next values.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_p_nxt     = r_p;
      w_a_nxt     = r_a;
      w_s_nxt     = r_s;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_hi_nxt    = r_hi;
      w_lo_nxt    = r_lo;
      case (r_state)
         IDLE: begin
            if (bus.Start) begin
               w_a_nxt     = w_a_ext;
               w_s_nxt     = ~w_a_ext + E'(1);
               w_p_nxt     = {{E{1'b0}}, w_b_ext, 1'b0};
               w_cnt_nxt   = '0;
               w_busy_nxt  = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            w_p_nxt   = w_p_step;
            w_cnt_nxt = r_cnt + CW'(1);
            if (r_cnt == CNT_LAST) w_state_nxt = DONE;
         end
         DONE: begin
            w_hi_nxt    = r_p[2*WIDTH:WIDTH+1];
            w_lo_nxt    = r_p[WIDTH:1];
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Datapath and registered outputs.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_cnt  <= '0;
         r_p    <= '0;
         r_a    <= '0;
         r_s    <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_hi   <= '0;
         r_lo   <= '0;
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_p    <= w_p_nxt;
         r_a    <= w_a_nxt;
         r_s    <= w_s_nxt;
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
         r_hi   <= w_hi_nxt;
         r_lo   <= w_lo_nxt;
      end
   end

   assign bus.Busy = r_busy;
   assign bus.Done = r_done;
   assign bus.Hi   = r_hi;
   assign bus.Lo   = r_lo;

endmodule

// File: tb/tb_booth_mult.sv
// Scoreboard bench for booth_mult at WIDTH=32 and WIDTH=8.
module tb_booth_mult;

   logic Clk = 1'b0;
   logic Reset_n = 1'b1;

   always #5 Clk = ~Clk;

   booth_mult_if #(.WIDTH(32)) if32 ();
   booth_mult_if #(.WIDTH(8))  if8  ();

   booth_mult #(.WIDTH(32)) u_dut32 (.Clk(Clk), .Reset_n(Reset_n), .bus(if32));
   booth_mult #(.WIDTH(8))  u_dut8  (.Clk(Clk), .Reset_n(Reset_n), .bus(if8));

   typedef struct packed { logic [31:0] hi; logic [31:0] lo; } exp32_t;
   typedef struct packed { logic [7:0]  hi; logic [7:0]  lo; } exp8_t;

   exp32_t q32[$];
   exp8_t  q8[$];
   int n_checks = 0;
   int n_pass   = 0;

   // Reference product: extend to double width, multiply, keep low half.
   function automatic logic [63:0] model32(input logic [31:0] a, input logic [31:0] b, input logic s);
      logic [63:0] ae, be;
      ae = s ? {{32{a[31]}}, a} : {32'h0, a};
      be = s ? {{32{b[31]}}, b} : {32'h0, b};
      return ae * be;
   endfunction

   function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
      logic [15:0] ae, be;
      ae = s ? {{8{a[7]}}, a} : {8'h0, a};
      be = s ? {{8{b[7]}}, b} : {8'h0, b};
      return ae * be;
   endfunction

   task automatic wait_done32(output int lat);
      int n = 0;
      while (n < 200) begin
         @(posedge Clk); #1; n++;
         if (if32.Done === 1'b1) begin lat = n; return; end
      end
      lat = -1;
   endtask

   task automatic wait_done8(output int lat);
      int n = 0;
      while (n < 200) begin
         @(posedge Clk); #1; n++;
         if (if8.Done === 1'b1) begin lat = n; return; end
      end
      lat = -1;
   endtask

   task automatic test_reset();
      if32.Start = 1'b0; if32.Signed = 1'b0; if32.MultA = '0; if32.MultB = '0;
      if8.Start  = 1'b0; if8.Signed  = 1'b0; if8.MultA  = '0; if8.MultB  = '0;
      #1 Reset_n = 1'b0;
      #20;
      n_checks++;
      if ({if32.Busy, if32.Done, if32.Hi, if32.Lo} !== 66'h0)
         $display("FAIL reset32: got busy=%b done=%b hi=%h lo=%h expected all 0", if32.Busy, if32.Done, if32.Hi, if32.Lo);
      else n_pass++;
      n_checks++;
      if ({if8.Busy, if8.Done, if8.Hi, if8.Lo} !== 18'h0)
         $display("FAIL reset8: got busy=%b done=%b hi=%h lo=%h expected all 0", if8.Busy, if8.Done, if8.Hi, if8.Lo);
      else n_pass++;
      @(negedge Clk);
      Reset_n = 1'b1;
   endtask

   task automatic test_directed32();
      logic [31:0] ta [5];
      logic [31:0] tb [5];
      logic        ts [5];
      logic [31:0] th [5];
      logic [31:0] tl [5];
      exp32_t e;
      int lat;
      ta = '{32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
      tb = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};
      ts = '{1'b1,         1'b1,         1'b0,         1'b1,         1'b0};
      th = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFE, 32'hC0000000, 32'h3FFFFFFF};
      tl = '{32'hFFFFFFEB, 32'h00000001, 32'h00000001, 32'h80000000, 32'h80000000};
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk);
         if32.MultA = ta[i]; if32.MultB = tb[i]; if32.Signed = ts[i]; if32.Start = 1'b1;
         q32.push_back({th[i], tl[i]});
         @(posedge Clk); #1;
         if32.Start = 1'b0;
         n_checks++;
         if (if32.Busy !== 1'b1) $display("FAIL dir%0d_busy: got %b expected 1", i, if32.Busy);
         else n_pass++;
         wait_done32(lat);
         n_checks++;
         if (lat != 34) $display("FAIL dir%0d_latency: got %0d expected 34", i, lat);
         else n_pass++;
         e = q32.pop_front();
         n_checks++;
         if ({if32.Hi, if32.Lo} !== {e.hi, e.lo})
            $display("FAIL dir%0d_result: got %h_%h expected %h_%h", i, if32.Hi, if32.Lo, e.hi, e.lo);
         else n_pass++;
         n_checks++;
         if (if32.Busy !== 1'b0) $display("FAIL dir%0d_busy_at_done: got %b expected 0", i, if32.Busy);
         else n_pass++;
         @(posedge Clk); #1;
         n_checks++;
         if ({if32.Done, if32.Busy, if32.Hi, if32.Lo} !== {2'b00, e.hi, e.lo})
            $display("FAIL dir%0d_hold: got done=%b busy=%b %h_%h expected done=0 busy=0 %h_%h",
                     i, if32.Done, if32.Busy, if32.Hi, if32.Lo, e.hi, e.lo);
         else n_pass++;
      end
   endtask

   task automatic test_ignore_start();
      exp32_t e;
      int lat = 0;
      logic busy_ok = 1'b1;
      @(negedge Clk);
      if32.MultA = 32'd7; if32.MultB = 32'hFFFFFFFD; if32.Signed = 1'b1; if32.Start = 1'b1;
      q32.push_back({32'hFFFFFFFF, 32'hFFFFFFEB});
      @(posedge Clk); #1;
      if32.Start = 1'b0;
      if32.MultA = 32'h12345678; if32.MultB = 32'h9ABCDEF0; if32.Signed = 1'b0;
      while (lat < 200) begin
         if (lat == 9) begin
            if32.MultA = 32'hDEADBEEF; if32.MultB = 32'h00000003; if32.Start = 1'b1;
         end else if (lat == 10) begin
            if32.Start = 1'b0;
         end
         @(posedge Clk); #1; lat++;
         if (if32.Done === 1'b1) break;
         if (if32.Busy !== 1'b1) busy_ok = 1'b0;
      end
      n_checks++;
      if (busy_ok !== 1'b1) $display("FAIL ign_busy: got busy dropped before done expected held");
      else n_pass++;
      n_checks++;
      if (lat != 34) $display("FAIL ign_latency: got %0d expected 34", lat);
      else n_pass++;
      e = q32.pop_front();
      n_checks++;
      if ({if32.Hi, if32.Lo} !== {e.hi, e.lo})
         $display("FAIL ign_result: got %h_%h expected %h_%h", if32.Hi, if32.Lo, e.hi, e.lo);
      else n_pass++;
      @(posedge Clk); #1;
      n_checks++;
      if (if32.Busy !== 1'b0) $display("FAIL ign_no_queue: got busy=%b expected 0", if32.Busy);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      exp32_t e;
      int lat;
      @(negedge Clk);
      if32.MultA = 32'h12345678; if32.MultB = 32'h9ABCDEF0; if32.Signed = 1'b1; if32.Start = 1'b1;
      @(posedge Clk); #1;
      if32.Start = 1'b0;
      repeat (19) @(posedge Clk);
      #3 Reset_n = 1'b0;
      q32.delete();
      #1;
      n_checks++;
      if ({if32.Busy, if32.Done, if32.Hi, if32.Lo} !== 66'h0)
         $display("FAIL rstmid_clear: got busy=%b done=%b hi=%h lo=%h expected all 0", if32.Busy, if32.Done, if32.Hi, if32.Lo);
      else n_pass++;
      @(negedge Clk);
      @(negedge Clk);
      Reset_n = 1'b1;
      if32.MultA = 32'd3; if32.MultB = 32'd5; if32.Signed = 1'b0; if32.Start = 1'b1;
      q32.push_back({32'h0, 32'd15});
      @(posedge Clk); #1;
      if32.Start = 1'b0;
      n_checks++;
      if (if32.Busy !== 1'b1) $display("FAIL rstmid_accept: got busy=%b expected 1", if32.Busy);
      else n_pass++;
      wait_done32(lat);
      n_checks++;
      if (lat != 34) $display("FAIL rstmid_latency: got %0d expected 34", lat);
      else n_pass++;
      e = q32.pop_front();
      n_checks++;
      if ({if32.Hi, if32.Lo} !== {e.hi, e.lo})
         $display("FAIL rstmid_result: got %h_%h expected %h_%h", if32.Hi, if32.Lo, e.hi, e.lo);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b;
      logic s;
      exp32_t e;
      int lat;
      @(negedge Clk);
      a = $urandom(); b = $urandom(); s = 1'($urandom_range(0, 1));
      if32.MultA = a; if32.MultB = b; if32.Signed = s; if32.Start = 1'b1;
      q32.push_back(model32(a, b, s));
      @(posedge Clk); #1;
      n_checks++;
      if (if32.Busy !== 1'b1) $display("FAIL b2b_first_accept: got busy=%b expected 1", if32.Busy);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         if (i < 3) begin
            a = $urandom(); b = $urandom(); s = 1'($urandom_range(0, 1));
            if32.MultA = a; if32.MultB = b; if32.Signed = s;
            q32.push_back(model32(a, b, s));
         end else begin
            if32.Start = 1'b0;
         end
         wait_done32(lat);
         n_checks++;
         if (lat != 34) $display("FAIL b2b%0d_latency: got %0d expected 34", i, lat);
         else n_pass++;
         e = q32.pop_front();
         n_checks++;
         if ({if32.Hi, if32.Lo} !== {e.hi, e.lo})
            $display("FAIL b2b%0d_result: got %h_%h expected %h_%h", i, if32.Hi, if32.Lo, e.hi, e.lo);
         else n_pass++;
         if (i < 3) begin
            @(posedge Clk); #1;
            n_checks++;
            if ({if32.Busy, if32.Done} !== 2'b10)
               $display("FAIL b2b%0d_restart: got busy=%b done=%b expected busy=1 done=0", i, if32.Busy, if32.Done);
            else n_pass++;
         end
      end
   endtask

   task automatic test_width8();
      logic [7:0] a, b;
      logic s;
      exp8_t e;
      int lat;
      for (int i = 0; i < 6; i++) begin
         if (i == 0)      begin a = 8'hFF; b = 8'h02; s = 1'b0; end
         else if (i == 1) begin a = 8'hFF; b = 8'h02; s = 1'b1; end
         else if (i == 2) begin a = 8'h80; b = 8'h80; s = 1'b1; end
         else begin a = 8'($urandom()); b = 8'($urandom()); s = 1'($urandom_range(0, 1)); end
         @(negedge Clk);
         if8.MultA = a; if8.MultB = b; if8.Signed = s; if8.Start = 1'b1;
         if (i == 0)      q8.push_back({8'h01, 8'hFE});
         else if (i == 1) q8.push_back({8'hFF, 8'hFE});
         else if (i == 2) q8.push_back({8'h40, 8'h00});
         else             q8.push_back(model8(a, b, s));
         @(posedge Clk); #1;
         if8.Start = 1'b0;
         wait_done8(lat);
         n_checks++;
         if (lat != 10) $display("FAIL w8_%0d_latency: got %0d expected 10", i, lat);
         else n_pass++;
         e = q8.pop_front();
         n_checks++;
         if ({if8.Hi, if8.Lo} !== {e.hi, e.lo})
            $display("FAIL w8_%0d_result: got %h_%h expected %h_%h", i, if8.Hi, if8.Lo, e.hi, e.lo);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_directed32();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      test_width8();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/booth_mult.md
# booth_mult

Parametrised sequential Booth multiplier for the datapath's Hi/Lo multiply path; supersedes the fixed 32-bit, signed-only multiplier. Adds operand width as a parameter, signed (MULT) and unsigned (MULTU) modes, a Start/Busy/Done handshake and a fixed, mode-independent latency. Sits beside the ALU and is driven by the control unit, which stalls on Busy and writes Hi/Lo on Done.

## Interface
- WIDTH, 32: operand width in bits; legal values are 4..64.
- Clk  in  1: clock, rising edge.
- Reset_n  in  1: asynchronous, active-low reset.
- Start  in  1: request; sampled only in IDLE.
- Signed  in  1: 1 = two's-complement operands, 0 = unsigned; sampled with Start.
- MultA  in  WIDTH: multiplicand; sampled with Start.
- MultB  in  WIDTH: multiplier; sampled with Start.
- Busy  out  1: high from the accepting edge until Done.
- Done  out  1: one-cycle pulse; Hi/Lo are valid from this cycle.
- Hi  out  WIDTH: upper half of the 2·WIDTH-bit product.
- Lo  out  WIDTH: lower half of the 2·WIDTH-bit product.

## Operation
- Reset values: Busy=0, Done=0, Hi=0, Lo=0. State=IDLE, counter=0, all internal registers 0.
- Both operands are extended to E=WIDTH+1 bits:
  - Signed=1: sign-extend.
  - Signed=0: zero-extend.
- Radix-2 Booth runs for E iterations in both modes.
- The product register P has 2E+1 bits, initialised to {E'0, B_ext, 1'b0}. Addend A = A_ext placed in the top E bits; S = -A_ext placed in the top E bits. All arithmetic is mod 2^(2E+1).
- Each iteration:
  - Examine P[1:0]: 01 → P+A; 10 → P+S; 00/11 → no add.
  - Then arithmetic shift right by 1, preserving the sign bit. This is an explicit requirement: a logical shift is wrong.
- Result = P[2·WIDTH:1], i.e. the low 2·WIDTH bits of the E×E product. This is exact for both modes.
- States:
  - IDLE: Start=1 → load A, S, P; counter=0; Busy=1; go to RUN. Start=0 → stay in IDLE.
  - RUN: one Booth iteration per cycle; counter++. When counter reaches E-1, go to DONE.
  - DONE: write Hi/Lo, Done=1, Busy=0, go to IDLE.
- Start while Busy is ignored, with no queueing.
- Start held high continuously starts a new operation on the cycle after Done, since the FSM is back in IDLE.
- Hi/Lo hold their value until the next DONE. They are not cleared by Start.
- Reset asserted mid-operation returns the block to reset values immediately; the partial result is discarded.
- Changes on MultA, MultB or Signed after acceptance have no effect.

## Timing
- Start sampled high at edge k: Busy=1 after edge k.
- RUN occupies edges k+1 … k+E.
- Done=1 and Hi/Lo are updated after edge k+E+1; Busy=0 in the same cycle.
- Latency from Start to Done is WIDTH+2 cycles; for WIDTH=32 this is 34 cycles.
- Throughput: one operation per WIDTH+3 cycles with back-to-back Start.
- Reset_n deassertion is synchronised externally. The first Start may arrive on the first edge after release.

## Structure
- Package mult_pkg holds:
  - the state typedef: enum {IDLE, RUN, DONE};
  - the Booth code constants (BOOTH_ADD=2'b01, BOOTH_SUB=2'b10);
  - a localparam helper for E=WIDTH+1.
- Sub-module booth_step: purely combinational, parametrised by E. It takes P, A, S and returns the next P (add/sub followed by arithmetic shift). The top level holds the FSM, counter and registers.
- Counter width is $clog2(WIDTH+2).

## Test plan
- WIDTH=32, Signed=1, A=7, B=0xFFFFFFFD (-3) → after 34 cycles Done=1, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
- WIDTH=32, A=B=0xFFFFFFFF: Signed=1 → Hi=0x00000000, Lo=0x00000001; Signed=0 → Hi=0xFFFFFFFE, Lo=0x00000001.
- WIDTH=32, Signed=1, A=0x80000000, B=0x7FFFFFFF → Hi=0xC0000000, Lo=0x80000000; Signed=0 with the same operands → Hi=0x3FFFFFFF, Lo=0x80000000.
- Start pulsed again at cycle 10 of an operation with different operands → ignored; the first result is delivered at cycle 34; Busy stays 1 throughout.
- Reset_n dropped at cycle 20 → Busy, Done, Hi and Lo are 0 asynchronously. After release, a new 3×5 operation gives Hi=0, Lo=15 after 34 cycles.
- WIDTH=8, Signed=0, A=0xFF, B=0x02 → Done after 10 cycles, Hi=0x01, Lo=0xFE; with Signed=1 → Hi=0xFF, Lo=0xFE.
